// File: rtl/wb_bus_arbiter.sv
// Round-robin WISHBONE bus arbiter with a per-grant watchdog that reclaims
// the bus from an owner whose slave has stopped responding.
module wb_bus_arbiter #(
    parameter int N_MASTERS      = 4,
    parameter int N_BITS_MASTER  = 2,
    parameter int TIMEOUT_CYCLES = 200,
    parameter int N_BITS_TIMEOUT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_MASTERS-1:0]     req_i,
    input  logic [N_MASTERS-1:0]     cyc_i,
    input  logic                     ACK_I,
    input  logic                     ERR_I,
    input  logic                     RTY_I,
    output logic [N_MASTERS-1:0]     gnt_o,
    output logic [N_BITS_MASTER-1:0] gnt_id_o,
    output logic                     bus_busy_o,
    output logic                     timeout_o
);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    localparam logic [N_BITS_TIMEOUT-1:0] CNT_LAST = N_BITS_TIMEOUT'(TIMEOUT_CYCLES - 1);
    localparam logic [N_BITS_TIMEOUT-1:0] CNT_MAX  = '1;
    localparam logic [N_BITS_MASTER-1:0]  LAST_ID  = N_BITS_MASTER'(N_MASTERS - 1);

    state_t                     state, state_nxt;
    logic [N_MASTERS-1:0]       gnt_nxt;
    logic [N_BITS_MASTER-1:0]   id_nxt;
    logic [N_BITS_MASTER-1:0]   ptr, ptr_nxt;
    logic [N_BITS_TIMEOUT-1:0]  cnt, cnt_nxt;
    logic                       tmo_nxt;

    logic                       found;
    logic [N_BITS_MASTER-1:0]   winner;
    logic [N_BITS_MASTER-1:0]   idx;
    logic                       owner_active;
    logic                       resp;

    assign owner_active = req_i[gnt_id_o] | cyc_i[gnt_id_o];
    assign resp         = ACK_I | ERR_I | RTY_I;

    // First requester at or after ptr, wrapping around the master list.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            idx = N_BITS_MASTER'((int'(ptr) + i) % N_MASTERS);
            if (!found && req_i[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_o;
        id_nxt    = gnt_id_o;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        tmo_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nxt   = N_MASTERS'(1) << winner;
                    id_nxt    = winner;
                    ptr_nxt   = (winner == LAST_ID) ? '0 : winner + 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!owner_active) begin
                    gnt_nxt   = '0;
                    state_nxt = RELEASE;
                end else if (resp) begin
                    cnt_nxt = '0;
                end else if (cnt == CNT_LAST) begin
                    gnt_nxt   = '0;
                    tmo_nxt   = 1'b1;
                    state_nxt = RELEASE;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RELEASE: state_nxt = IDLE;
            default: begin
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gnt_o      <= '0;
            gnt_id_o   <= '0;
            ptr        <= '0;
            cnt        <= '0;
            timeout_o  <= 1'b0;
            bus_busy_o <= 1'b0;
        end else begin
            state      <= state_nxt;
            gnt_o      <= gnt_nxt;
            gnt_id_o   <= id_nxt;
            ptr        <= ptr_nxt;
            cnt        <= cnt_nxt;
            timeout_o  <= tmo_nxt;
            bus_busy_o <= |gnt_nxt;
        end
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter: a behavioural arbitration model feeds a scoreboard
// queue that a separate monitor drains one entry per clock.
module tb_wb_bus_arbiter;
    localparam int N  = 4;
    localparam int NB = 2;
    localparam int T  = 200;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req, cyc;
    logic          ack, err, rty;
    logic [N-1:0]  gnt;
    logic [NB-1:0] gnt_id;
    logic          busy, tmo;

    wb_bus_arbiter #(.N_MASTERS(N), .N_BITS_MASTER(NB), .TIMEOUT_CYCLES(T), .N_BITS_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .req_i(req), .cyc_i(cyc),
        .ACK_I(ack), .ERR_I(err), .RTY_I(rty),
        .gnt_o(gnt), .gnt_id_o(gnt_id), .bus_busy_o(busy), .timeout_o(tmo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]  gnt;
        logic [NB-1:0] id;
        logic          busy;
        logic          tmo;
    } exp_t;

    exp_t sb[$];
    int   grants[$];
    int   total = 0;
    int   bad   = 0;
    int   tmo_seen = 0;

    // Reference: who owns the bus, who owned it last, whose turn is next,
    // how long the owner has gone without a slave response.
    int   m_owner  = -1;
    int   m_last   = 0;
    int   m_ptr    = 0;
    int   m_silent = 0;
    bit   m_gap    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        exp_t e;
        bit   pulse;
        bit   found;
        int   c;
        pulse = 0;
        found = 0;
        if (rst) begin
            m_owner = -1; m_gap = 0; m_last = 0; m_ptr = 0; m_silent = 0;
        end else if (m_owner >= 0) begin
            if (!(req[m_owner] | cyc[m_owner])) begin
                m_owner = -1; m_gap = 1;
            end else if (ack | err | rty) begin
                m_silent = 0;
            end else if (m_silent == T - 1) begin
                m_owner = -1; m_gap = 1; pulse = 1;
            end else begin
                m_silent++;
            end
        end else if (m_gap) begin
            m_gap = 0;
        end else begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (!found && req[c]) begin
                    found = 1; m_owner = c; m_last = c; m_ptr = (c + 1) % N; m_silent = 0;
                end
            end
        end
        e.gnt  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        e.id   = NB'(m_last);
        e.busy = (m_owner >= 0);
        e.tmo  = pulse;
        sb.push_back(e);
    endtask

    task automatic drive(input logic r, input logic [N-1:0] rq, input logic [N-1:0] cy,
                         input logic a, input logic e, input logic t);
        @(negedge clk);
        rst = r; req = rq; cyc = cy; ack = a; err = e; rty = t;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, '0, '0, 0, 0, 0);
    endtask

    // Monitor: compares the DUT against the oldest queued expectation.
    initial begin
        exp_t       e;
        logic [N-1:0] prev;
        prev = '0;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("gnt",     32'(gnt),  32'(e.gnt));
                chk("gnt_id",  32'(gnt_id), 32'(e.id));
                chk("busy",    32'(busy), 32'(e.busy));
                chk("timeout", 32'(tmo),  32'(e.tmo));
                chk("onehot0", 32'($onehot0(gnt)), 32'd1);
                if (prev == '0 && gnt != '0) grants.push_back(int'(gnt_id));
                if (tmo) tmo_seen++;
                prev = gnt;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int held;
        int t0;
        logic [N-1:0] rq, cy;
        rst = 1; req = '0; cyc = '0; ack = 0; err = 0; rty = 0;
        drive(1, '0, '0, 0, 0, 0);
        drive(1, '0, '0, 0, 0, 0);

        // Single master: request, CYC a cycle later, then drop.
        drive(0, 4'b0001, 4'b0000, 0, 0, 0);
        repeat (5) drive(0, 4'b0001, 4'b0001, 0, 0, 0);
        idle(4);

        // All masters requesting: rotation with 3-cycle bursts.
        drive(1, '0, '0, 0, 0, 0);
        idle(1);
        #2 grants.delete();
        held = 0;
        for (int i = 0; i < 60; i++) begin
            if (m_owner >= 0) begin
                if (held < 3) begin
                    drive(0, 4'hF, N'(1) << m_owner, 1, 0, 0);
                    held++;
                end else begin
                    drive(0, 4'hF & ~(N'(1) << m_owner), '0, 0, 0, 0);
                    held = 0;
                end
            end else begin
                drive(0, 4'hF, '0, 0, 0, 0);
                held = 0;
            end
        end
        idle(4);
        chk("rr_count", 32'(grants.size() >= 5), 32'd1);
        if (grants.size() >= 5) begin
            chk("rr_0", 32'(grants[0]), 32'd0);
            chk("rr_1", 32'(grants[1]), 32'd1);
            chk("rr_2", 32'(grants[2]), 32'd2);
            chk("rr_3", 32'(grants[3]), 32'd3);
            chk("rr_4", 32'(grants[4]), 32'd0);
        end

        // Silent slave under master 2: forced release.
        drive(1, '0, '0, 0, 0, 0);
        t0 = tmo_seen;
        drive(0, 4'b0100, 4'b0100, 0, 0, 0);
        repeat (205) drive(0, 4'b0000, 4'b0100, 0, 0, 0);
        idle(3);
        chk("timeout_pulses", 32'(tmo_seen - t0), 32'd1);

        // Responses that keep the watchdog from ever firing.
        t0 = tmo_seen;
        drive(0, 4'b0010, 4'b0010, 0, 0, 0);
        for (int i = 0; i < 600; i++) drive(0, 4'b0010, 4'b0010, (i % 199) == 198, 0, 0);
        idle(3);
        drive(0, 4'b0001, 4'b0001, 0, 0, 0);
        for (int i = 0; i < 250; i++) drive(0, 4'b0001, 4'b0001, 0, i == 199, 0);
        idle(3);
        chk("no_timeout", 32'(tmo_seen - t0), 32'd0);

        // Reset mid-burst with master 3 still requesting.
        drive(1, '0, '0, 0, 0, 0);
        drive(0, 4'b1000, 4'b0000, 0, 0, 0);
        repeat (3) drive(0, 4'b1000, 4'b1000, 1, 0, 0);
        drive(1, 4'b1000, 4'b1000, 1, 0, 0);
        repeat (4) drive(0, 4'b1000, 4'b1000, 1, 0, 0);
        idle(4);

        // Pointer wrap: grant 2, then 0110 goes to 1, then to 2.
        #2 grants.delete();
        drive(0, 4'b0100, 4'b0100, 0, 0, 0);
        drive(0, 4'b0100, 4'b0100, 1, 0, 0);
        idle(3);
        drive(0, 4'b0110, 4'b0110, 0, 0, 0);
        drive(0, 4'b0010, 4'b0010, 1, 0, 0);
        idle(3);
        drive(0, 4'b0110, 4'b0110, 0, 0, 0);
        drive(0, 4'b0100, 4'b0100, 1, 0, 0);
        idle(3);
        chk("ptr_count", 32'(grants.size()), 32'd3);
        if (grants.size() == 3) begin
            chk("ptr_0", 32'(grants[0]), 32'd2);
            chk("ptr_1", 32'(grants[1]), 32'd1);
            chk("ptr_2", 32'(grants[2]), 32'd2);
        end

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            rq = '0;
            cy = '0;
            for (int b = 0; b < N; b++) begin
                rq[b] = ($urandom_range(0, 99) < 40);
                cy[b] = ($urandom_range(0, 99) < 70);
            end
            drive($urandom_range(0, 199) == 0, rq, cy,
                  $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 2);
        end
        idle(4);

        for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
        #3;
        if (sb.size() != 0) chk("drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
